// File: rtl/mmap_pkg.sv
// Shared constants and types for the branch-statistics read window.
package mmap_pkg;

  localparam logic [15:0] BASE_ADDR_DEF = 16'hC008;

  localparam logic [2:0] OFF_BR    = 3'd0;
  localparam logic [2:0] OFF_HIT   = 3'd1;
  localparam logic [2:0] OFF_MISPR = 3'd2;
  localparam logic [2:0] OFF_STAT  = 3'd3;
  localparam logic [2:0] OFF_TIMER = 3'd4;

  localparam int ST_EN          = 0;
  localparam int ST_BR_WRAP     = 1;
  localparam int ST_HIT_WRAP    = 2;
  localparam int ST_MISPR_WRAP  = 3;
  localparam int ST_TIMER_WRAP  = 4;
  localparam int ST_SNAP_VLD    = 5;

  typedef struct packed {
    logic [9:0] rsvd;
    logic       snap_vld;
    logic       timer_wrap;
    logic       mispr_wrap;
    logic       hit_wrap;
    logic       br_wrap;
    logic       stats_en;
  } stat_word_t;

endpackage

// File: rtl/mmap_stats_rd_wrap_detect.sv
// Previous-value register plus sticky wrap flag; a wrap on the same edge
// as a clear keeps the flag set so the event is never lost.
module wrap_detect #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] cur,
  input  logic          clr,
  output logic          flag
);

  logic [DW-1:0] prev_q, prev_d;
  logic          flag_q, flag_d;
  logic          wrap;

  always_comb begin
    prev_d = cur;
    wrap   = (prev_q == {DW{1'b1}}) && (cur == '0);
    flag_d = flag_q;
    if (clr)  flag_d = 1'b0;
    if (wrap) flag_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      flag_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      flag_q <= flag_d;
    end
  end

  assign flag = flag_q;

endmodule

// File: rtl/mmap_stats_rd.sv
// Read-side responder for the branch-statistics window: coherent snapshot
// on an offset-0 read, sticky wrap flags cleared by a status read.
module mmap_stats_rd
  import mmap_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter int          DW        = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          re,
  input  logic [15:0]   addr,
  input  logic          stats_en,
  input  logic [DW-1:0] br_cnt,
  input  logic [DW-1:0] hit_cnt,
  input  logic [DW-1:0] mispr_cnt,
  input  logic [DW-1:0] timer,
  output logic [DW-1:0] rdata,
  output logic          rd_vld,
  output logic          in_window
);

  logic [2:0]    off;
  logic          stat_rd;
  logic          br_wrap, hit_wrap, mispr_wrap, timer_wrap;
  stat_word_t    stat;

  logic [DW-1:0] rdata_q, rdata_d;
  logic          rd_vld_q, rd_vld_d;
  logic [DW-1:0] hit_snap_q, hit_snap_d;
  logic [DW-1:0] mispr_snap_q, mispr_snap_d;
  logic [DW-1:0] timer_snap_q, timer_snap_d;
  logic          snap_vld_q, snap_vld_d;

  assign in_window = re && (addr[15:3] == BASE_ADDR[15:3]);
  assign off       = addr[2:0] - BASE_ADDR[2:0];
  assign stat_rd   = in_window && (off == OFF_STAT);

  wrap_detect #(.DW(DW)) u_wrap_br (
    .clk(clk), .rst_n(rst_n), .cur(br_cnt), .clr(stat_rd), .flag(br_wrap));
  wrap_detect #(.DW(DW)) u_wrap_hit (
    .clk(clk), .rst_n(rst_n), .cur(hit_cnt), .clr(stat_rd), .flag(hit_wrap));
  wrap_detect #(.DW(DW)) u_wrap_mispr (
    .clk(clk), .rst_n(rst_n), .cur(mispr_cnt), .clr(stat_rd), .flag(mispr_wrap));
  wrap_detect #(.DW(DW)) u_wrap_timer (
    .clk(clk), .rst_n(rst_n), .cur(timer), .clr(stat_rd), .flag(timer_wrap));

  always_comb begin
    stat            = '0;
    stat.stats_en   = stats_en;
    stat.br_wrap    = br_wrap;
    stat.hit_wrap   = hit_wrap;
    stat.mispr_wrap = mispr_wrap;
    stat.timer_wrap = timer_wrap;
    stat.snap_vld   = snap_vld_q;

    rdata_d      = '0;
    rd_vld_d     = in_window;
    hit_snap_d   = hit_snap_q;
    mispr_snap_d = mispr_snap_q;
    timer_snap_d = timer_snap_q;
    snap_vld_d   = snap_vld_q;

    if (in_window) begin
      case (off)
        OFF_BR: begin
          // Live branch count plus a same-edge capture of the others.
          rdata_d      = br_cnt;
          hit_snap_d   = hit_cnt;
          mispr_snap_d = mispr_cnt;
          timer_snap_d = timer;
          snap_vld_d   = 1'b1;
        end
        OFF_HIT:   rdata_d = hit_snap_q;
        OFF_MISPR: rdata_d = mispr_snap_q;
        OFF_STAT: begin
          rdata_d    = DW'(stat);
          snap_vld_d = 1'b0;
        end
        OFF_TIMER: rdata_d = timer_snap_q;
        default:   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q      <= '0;
      rd_vld_q     <= 1'b0;
      hit_snap_q   <= '0;
      mispr_snap_q <= '0;
      timer_snap_q <= '0;
      snap_vld_q   <= 1'b0;
    end else begin
      rdata_q      <= rdata_d;
      rd_vld_q     <= rd_vld_d;
      hit_snap_q   <= hit_snap_d;
      mispr_snap_q <= mispr_snap_d;
      timer_snap_q <= timer_snap_d;
      snap_vld_q   <= snap_vld_d;
    end
  end

  assign rdata  = rdata_q;
  assign rd_vld = rd_vld_q;

endmodule

// File: tb/tb_mmap_stats_rd.sv
// Directed bench for mmap_stats_rd: inputs change on the falling edge,
// results are checked on the following falling edge.
module tb_mmap_stats_rd;

  logic        clk;
  logic        rst_n;
  logic        re;
  logic [15:0] addr;
  logic        stats_en;
  logic [15:0] br_cnt, hit_cnt, mispr_cnt, timer;
  logic [15:0] rdata;
  logic        rd_vld;
  logic        in_window;

  int n_cmp = 0;
  int n_err = 0;

  mmap_stats_rd #(.BASE_ADDR(16'hC008), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .re(re), .addr(addr), .stats_en(stats_en),
    .br_cnt(br_cnt), .hit_cnt(hit_cnt), .mispr_cnt(mispr_cnt), .timer(timer),
    .rdata(rdata), .rd_vld(rd_vld), .in_window(in_window)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [15:0] a);
    re   = 1'b1;
    addr = a;
    @(negedge clk);
  endtask

  task automatic idle();
    re = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
    issue(a);
    check({tag, "_vld"}, {15'd0, rd_vld}, 16'd1);
    check(tag, rdata, exp);
  endtask

  initial begin
    rst_n = 1'b0; re = 1'b0; addr = 16'h0000; stats_en = 1'b0;
    br_cnt = 16'h0; hit_cnt = 16'h0; mispr_cnt = 16'h0; timer = 16'h0;
    @(negedge clk); @(negedge clk);
    check("rst_rdata", rdata, 16'h0000);
    check("rst_vld", {15'd0, rd_vld}, 16'h0);
    rst_n = 1'b1;
    stats_en = 1'b1;
    @(negedge clk);

    re = 1'b1; addr = 16'hC00B; #1;
    check("inwin_c00b", {15'd0, in_window}, 16'h1);
    @(negedge clk);
    check("stat0_vld", {15'd0, rd_vld}, 16'h1);
    check("stat0", rdata, 16'h0001);
    rd("hit_presnap", 16'hC009, 16'h0000);
    idle();
    check("idle_vld", {15'd0, rd_vld}, 16'h0);

    br_cnt = 16'h0012; hit_cnt = 16'h000F; mispr_cnt = 16'h0003; timer = 16'h1234;
    rd("br_live", 16'hC008, 16'h0012);
    hit_cnt = 16'h0020;
    rd("snap_hit", 16'hC009, 16'h000F);
    rd("snap_mispr", 16'hC00A, 16'h0003);
    rd("snap_timer", 16'hC00C, 16'h1234);
    idle();

    rd("stat_snapvld", 16'hC00B, 16'h0021);
    rd("stat_snapclr", 16'hC00B, 16'h0001);

    timer = 16'hFFFF; idle();
    timer = 16'h0000; idle();
    rd("stat_twrap", 16'hC00B, 16'h0011);
    rd("stat_twrap_clr", 16'hC00B, 16'h0001);

    br_cnt = 16'hFFFF; idle();
    br_cnt = 16'h0000;
    rd("stat_brwrap_same", 16'hC00B, 16'h0001);
    rd("stat_brwrap_next", 16'hC00B, 16'h0003);
    rd("stat_brwrap_clr", 16'hC00B, 16'h0001);

    hit_cnt = 16'h0000; idle();
    rd("stat_nowrap_rst", 16'hC00B, 16'h0001);

    rd("off7", 16'hC00F, 16'h0000);
    rd("off5", 16'hC00D, 16'h0000);
    re = 1'b1; addr = 16'hC010; #1;
    check("inwin_c010", {15'd0, in_window}, 16'h0);
    @(negedge clk);
    check("vld_c010", {15'd0, rd_vld}, 16'h0);
    re = 1'b1; addr = 16'hC007; #1;
    check("inwin_c007", {15'd0, in_window}, 16'h0);
    @(negedge clk);
    check("vld_c007", {15'd0, rd_vld}, 16'h0);
    re = 1'b0; addr = 16'hC008; #1;
    check("inwin_nore", {15'd0, in_window}, 16'h0);
    @(negedge clk);

    br_cnt = 16'h0055; hit_cnt = 16'h0077; mispr_cnt = 16'h0066; timer = 16'h0099;
    rd("br_live2", 16'hC008, 16'h0055);
    rst_n = 1'b0; re = 1'b1; addr = 16'hC00B;
    @(negedge clk); @(negedge clk);
    check("midrst_rdata", rdata, 16'h0000);
    check("midrst_vld", {15'd0, rd_vld}, 16'h0);
    rst_n = 1'b1; re = 1'b0; #1;
    check("postrst_vld", {15'd0, rd_vld}, 16'h0);
    @(negedge clk);
    rd("postrst_stat", 16'hC00B, 16'h0001);
    rd("postrst_hit", 16'hC009, 16'h0000);
    rd("postrst_mispr", 16'hC00A, 16'h0000);
    rd("postrst_timer", 16'hC00C, 16'h0000);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
